sync_pulse_tx: RTL
==================

// Module: sync_pulse_tx
//
// PURPOSE
// Transmit side of the level-sampled event link. Converts single-cycle event
// pulses from the local clk domain into a held level pulse with guaranteed
// minimum high and low times, so a remote 3-stage majority-vote synchronizer
// samples every event exactly once. Events that arrive while a pulse is in
// flight are counted and replayed back to back; the event count is preserved.
//
// PARAMETERS
// HIGH_CYCLES  4  clk cycles out_sig is held active per event (>=1; >=3 for majority receivers)
// LOW_CYCLES   4  clk cycles out_sig is held idle after each event (>=1; >=3 for majority receivers)
// PENDING_W    4  width of pending-event counter; saturates at 2**PENDING_W-1
// IDLE_VALUE   0  inactive level of out_sig; the active level is ~IDLE_VALUE
//
// PORTS
// clk          in   1          system clock, all logic on posedge
// nrst         in   1          asynchronous active-low reset
// in_pulse     in   1          event request, one event per high cycle
// clr_overflow in   1          clears the overflow flag
// out_sig      out  1          registered line to the remote synchronizer
// busy         out  1          1 while in HIGH or GAP
// pending      out  PENDING_W  queued events not yet transmitted
// overflow     out  1          sticky: an event was dropped
//
// BEHAVIOUR
// - Reset (async, nrst=0): state=IDLE, out_sig=IDLE_VALUE, busy=0, pending=0,
//   overflow=0, phase counter=0. Takes effect mid-pulse; queued events are lost.
// - out_sig is driven directly from a flop, never from combinational logic (glitch-free).
// - States: IDLE, HIGH, GAP. Phase counter width $clog2(max(HIGH_CYCLES,LOW_CYCLES)+1).
// - IDLE: if in_pulse or pending>0 -> HIGH next cycle, out_sig active, counter=1.
//   When both hold, the queued event is consumed and in_pulse increments pending (net 0).
// - HIGH: out_sig active for exactly HIGH_CYCLES cycles, then -> GAP, out_sig idle.
// - GAP: out_sig idle for exactly LOW_CYCLES cycles, then -> HIGH if in_pulse
//   or pending>0 (same consume rule as IDLE), else -> IDLE.
// - Latency: in_pulse at edge N in IDLE -> out_sig active from edge N+1.
//   Back-to-back events give a period of HIGH_CYCLES+LOW_CYCLES.
// - Pending rules: in_pulse not consumed this cycle -> pending+1.
//   A consume with no in_pulse -> pending-1. Both -> unchanged.
// - Saturation: in_pulse when pending=2**PENDING_W-1 and no consume -> event
//   dropped, pending held, overflow<=1.
// - overflow clears on clr_overflow; a drop in the same cycle wins (overflow stays 1).
// - busy = (state != IDLE), registered together with state.
// - The exact transmitted count equals the accepted in_pulse count minus the drops.
//
// TESTING
// 1 Reset: hold nrst=0 with in_pulse=1 -> out_sig=IDLE_VALUE, pending=0, busy=0;
//   release -> first pulse starts the edge after the first sampled in_pulse.
// 2 Single event (defaults): in_pulse at edge 10 -> out_sig=1 for edges 11..14,
//   0 for edges 15..18, busy=1 for edges 11..18, IDLE at edge 19.
// 3 Burst: 3 consecutive in_pulse from IDLE -> pending goes 0,1,2 and then drains;
//   3 high pulses, each 4 cycles high and 4 low, no IDLE between them.
// 4 Saturation: PENDING_W=2, 6 in_pulse during one HIGH -> pending stops at 3,
//   overflow=1, exactly 4 pulses emitted; clr_overflow with no drop -> overflow=0.
// 5 Simultaneous: clr_overflow and a dropped in_pulse in the same cycle -> overflow
//   stays 1; in_pulse on the last GAP cycle with pending=1 -> pending stays 1, HIGH next.
// 6 Receiver check: feed out_sig into a 3-tap majority synchronizer on a clock 1.3x
//   slower and randomise 200 in_pulse -> the count of receiver rising edges equals
//   the transmitted count, with overflow=0.

Source files
------------

// File: rtl/sync_pulse_tx.sv
// rtl/sync_pulse_tx.sv - event pulse to held-level transmitter with replay queue
module sync_pulse_tx #(
  parameter int   HIGH_CYCLES = 4,
  parameter int   LOW_CYCLES  = 4,
  parameter int   PENDING_W   = 4,
  parameter logic IDLE_VALUE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 in_pulse,
  input  logic                 clr_overflow,
  output logic                 out_sig,
  output logic                 busy,
  output logic [PENDING_W-1:0] pending,
  output logic                 overflow
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0]        HIGH_LAST = CW'(HIGH_CYCLES);
  localparam logic [CW-1:0]        LOW_LAST  = CW'(LOW_CYCLES);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [PENDING_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [PENDING_W-1:0] pending_nx;
  logic                 overflow_nx;
  logic                 out_nx;
  logic                 busy_nx;
  logic                 launch;
  logic                 has_queued;
  logic                 drop;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    launch      = 1'b0;
    has_queued  = (pending != '0);
    pending_nx  = pending;
    drop        = 1'b0;
    overflow_nx = overflow;

    case (state)
      IDLE: launch = in_pulse || has_queued;
      HIGH: begin
        if (cnt == HIGH_LAST) begin
          state_nx = GAP;
          cnt_nx   = CNT_ONE;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == LOW_LAST) begin
          if (in_pulse || has_queued) begin
            launch = 1'b1;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    if (launch) begin
      state_nx = HIGH;
      cnt_nx   = CNT_ONE;
    end

    // A launch takes the oldest queued event first; a fresh in_pulse then refills its slot.
    if (launch && has_queued) begin
      if (!in_pulse) pending_nx = pending - 1'b1;
    end else if (in_pulse && !launch) begin
      if (pending == PEND_MAX) drop = 1'b1;
      else                     pending_nx = pending + 1'b1;
    end

    if (drop)              overflow_nx = 1'b1;
    else if (clr_overflow) overflow_nx = 1'b0;

    out_nx  = (state_nx == HIGH) ? ~IDLE_VALUE : IDLE_VALUE;
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= '0;
      out_sig  <= IDLE_VALUE;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      out_sig  <= out_nx;
      busy     <= busy_nx;
      pending  <= pending_nx;
      overflow <= overflow_nx;
    end
  end

endmodule
